// File: rtl/rtc_calendar_core_pkg.sv
// Shared constants and BCD calendar helpers for the century clock.
package century_clock_pkg;
  localparam int         BCD_W    = 8;
  localparam logic [7:0] RST_SEC  = 8'h00;
  localparam logic [7:0] RST_MIN  = 8'h00;
  localparam logic [7:0] RST_HOUR = 8'h00;
  localparam logic [7:0] RST_DAY  = 8'h01;
  localparam logic [7:0] RST_MON  = 8'h01;
  localparam logic [7:0] RST_YEAR = 8'h00;

  function automatic logic bcd_valid(input logic [BCD_W-1:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  // A two-digit BCD value is divisible by 4 when an even tens digit pairs
  // with ones 0/4/8, or an odd tens digit pairs with ones 2/6.
  function automatic logic is_leap(input logic [BCD_W-1:0] year_bcd,
                                   input logic [BCD_W-1:0] cent_bcd);
    logic [BCD_W-1:0] v;
    v = (year_bcd == 8'h00) ? cent_bcd : year_bcd;
    if (v[4]) return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
    else      return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
  endfunction

  function automatic logic [BCD_W-1:0] days_in_month(input logic [BCD_W-1:0] mon_bcd,
                                                     input logic leap);
    case (mon_bcd)
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      8'h02:                      return leap ? 8'h29 : 8'h28;
      default:                    return 8'h31;
    endcase
  endfunction
endpackage

// File: rtl/rtc_calendar_core_bcd2_counter.sv
// Two-digit BCD field counter; wraps MAX->MIN, max_in can lower the wrap point.
module bcd2_counter
  import century_clock_pkg::*;
#(
  parameter logic [BCD_W-1:0] MIN     = 8'h00,
  parameter logic [BCD_W-1:0] MAX     = 8'h59,
  parameter logic [BCD_W-1:0] RST_VAL = MIN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic [BCD_W-1:0] max_in,
  output logic [BCD_W-1:0] value,
  output logic             carry_out
);
  logic [BCD_W-1:0] value_q, value_d, max_eff;
  logic             at_max;

  assign max_eff   = (max_in > MAX) ? MAX : max_in;
  assign at_max    = (value_q == max_eff);
  assign carry_out = inc && at_max;
  assign value     = value_q;

  always_comb begin
    value_d = value_q;
    if (load)
      value_d = load_val;
    else if (inc) begin
      if (at_max)                   value_d = MIN;
      else if (value_q[3:0] == 4'd9) value_d = {value_q[7:4] + 4'd1, 4'd0};
      else                          value_d = {value_q[7:4], value_q[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) value_q <= RST_VAL;
    else     value_q <= value_d;
endmodule

// File: rtl/rtc_calendar_core.sv
// Calendar timekeeping core: prescales ce_in to 1 Hz and advances a BCD
// date/time carry chain in a single edge; accepts validated set commands.
module rtc_calendar_core
  import century_clock_pkg::*;
#(
  parameter int               TICKS_PER_SEC = 100_000,
  parameter logic [BCD_W-1:0] RST_CENT      = 8'h20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce_in,
  input  logic             run,
  input  logic             set_stb,
  input  logic [BCD_W-1:0] set_sec,
  input  logic [BCD_W-1:0] set_min,
  input  logic [BCD_W-1:0] set_hour,
  input  logic [BCD_W-1:0] set_day,
  input  logic [BCD_W-1:0] set_mon,
  input  logic [BCD_W-1:0] set_year,
  input  logic [BCD_W-1:0] set_cent,
  output logic [BCD_W-1:0] sec_bcd,
  output logic [BCD_W-1:0] min_bcd,
  output logic [BCD_W-1:0] hour_bcd,
  output logic [BCD_W-1:0] day_bcd,
  output logic [BCD_W-1:0] mon_bcd,
  output logic [BCD_W-1:0] year_bcd,
  output logic [BCD_W-1:0] cent_bcd,
  output logic             tick_1hz,
  output logic             set_ack,
  output logic             set_err
);
  localparam int            PW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0]    pre_q, pre_d;
  logic             tick_q, tick_d, ack_q, ack_d, err_q, err_d;
  logic             ce_run, wrap, set_fields_ok, set_ok, sec_adv;
  logic             sec_c, min_c, hour_c, day_c, mon_c, year_c, cent_carry_unused;
  logic [BCD_W-1:0] dim_cur;

  assign ce_run  = ce_in && run;
  assign wrap    = ce_run && (pre_q == PRE_LAST);
  assign set_ok  = set_stb && set_fields_ok;
  assign sec_adv = wrap && !set_ok;
  assign dim_cur = days_in_month(mon_bcd, is_leap(year_bcd, cent_bcd));

  // Nibble checks make plain magnitude compares valid on the BCD bytes.
  always_comb begin
    set_fields_ok = bcd_valid(set_sec) && bcd_valid(set_min) && bcd_valid(set_hour) &&
                    bcd_valid(set_day) && bcd_valid(set_mon) && bcd_valid(set_year) &&
                    bcd_valid(set_cent) &&
                    (set_sec <= 8'h59) && (set_min <= 8'h59) && (set_hour <= 8'h23) &&
                    (set_mon >= 8'h01) && (set_mon <= 8'h12) && (set_day >= 8'h01) &&
                    (set_day <= days_in_month(set_mon, is_leap(set_year, set_cent)));
  end

  always_comb begin
    pre_d  = pre_q;
    if (set_ok)      pre_d = '0;
    else if (ce_run) pre_d = wrap ? '0 : pre_q + 1'b1;
    tick_d = sec_adv;
    ack_d  = set_ok;
    err_d  = set_stb && !set_fields_ok;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
    end

  assign tick_1hz = tick_q;
  assign set_ack  = ack_q;
  assign set_err  = err_q;

  bcd2_counter #(.MIN(8'h00), .MAX(8'h59), .RST_VAL(RST_SEC)) u_sec (
    .clk(clk), .rst(rst), .inc(sec_adv), .load(set_ok), .load_val(set_sec),
    .max_in(8'h59), .value(sec_bcd), .carry_out(sec_c));

  bcd2_counter #(.MIN(8'h00), .MAX(8'h59), .RST_VAL(RST_MIN)) u_min (
    .clk(clk), .rst(rst), .inc(sec_c), .load(set_ok), .load_val(set_min),
    .max_in(8'h59), .value(min_bcd), .carry_out(min_c));

  bcd2_counter #(.MIN(8'h00), .MAX(8'h23), .RST_VAL(RST_HOUR)) u_hour (
    .clk(clk), .rst(rst), .inc(min_c), .load(set_ok), .load_val(set_hour),
    .max_in(8'h23), .value(hour_bcd), .carry_out(hour_c));

  bcd2_counter #(.MIN(8'h01), .MAX(8'h31), .RST_VAL(RST_DAY)) u_day (
    .clk(clk), .rst(rst), .inc(hour_c), .load(set_ok), .load_val(set_day),
    .max_in(dim_cur), .value(day_bcd), .carry_out(day_c));

  bcd2_counter #(.MIN(8'h01), .MAX(8'h12), .RST_VAL(RST_MON)) u_mon (
    .clk(clk), .rst(rst), .inc(day_c), .load(set_ok), .load_val(set_mon),
    .max_in(8'h12), .value(mon_bcd), .carry_out(mon_c));

  bcd2_counter #(.MIN(8'h00), .MAX(8'h99), .RST_VAL(RST_YEAR)) u_year (
    .clk(clk), .rst(rst), .inc(mon_c), .load(set_ok), .load_val(set_year),
    .max_in(8'h99), .value(year_bcd), .carry_out(year_c));

  // Century 99->00 wraps with nowhere to carry.
  bcd2_counter #(.MIN(8'h00), .MAX(8'h99), .RST_VAL(RST_CENT)) u_cent (
    .clk(clk), .rst(rst), .inc(year_c), .load(set_ok), .load_val(set_cent),
    .max_in(8'h99), .value(cent_bcd), .carry_out(cent_carry_unused));
endmodule

// File: tb/tb_rtc_calendar_core.sv
// Directed + randomized bench for rtc_calendar_core against an integer calendar model.
module tb_rtc_calendar_core;
  localparam int TPS = 4;

  logic       clk = 1'b0, rst = 1'b1, ce_in = 1'b0, run = 1'b0, set_stb = 1'b0;
  logic [7:0] set_sec = '0, set_min = '0, set_hour = '0, set_day = '0;
  logic [7:0] set_mon = '0, set_year = '0, set_cent = '0;
  logic [7:0] sec_bcd, min_bcd, hour_bcd, day_bcd, mon_bcd, year_bcd, cent_bcd;
  logic       tick_1hz, set_ack, set_err;

  rtc_calendar_core #(.TICKS_PER_SEC(TPS), .RST_CENT(8'h20)) dut (
    .clk(clk), .rst(rst), .ce_in(ce_in), .run(run), .set_stb(set_stb),
    .set_sec(set_sec), .set_min(set_min), .set_hour(set_hour), .set_day(set_day),
    .set_mon(set_mon), .set_year(set_year), .set_cent(set_cent),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hour_bcd(hour_bcd), .day_bcd(day_bcd),
    .mon_bcd(mon_bcd), .year_bcd(year_bcd), .cent_bcd(cent_bcd),
    .tick_1hz(tick_1hz), .set_ack(set_ack), .set_err(set_err));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  // Model keeps the full four-digit year as one integer.
  int m_sec, m_min, m_hour, m_day, m_mon, m_year, m_pre;
  bit m_tick, m_ack, m_err;

  function automatic bit leap(input int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int dim(input int mo, input int y);
    case (mo)
      1, 3, 5, 7, 8, 10, 12: return 31;
      4, 6, 9, 11:           return 30;
      2:                     return leap(y) ? 29 : 28;
      default:               return 0;
    endcase
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int dec(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit set_valid();
    logic [7:0] b [7];
    b = '{set_sec, set_min, set_hour, set_day, set_mon, set_year, set_cent};
    foreach (b[i]) if (b[i][7:4] > 4'd9 || b[i][3:0] > 4'd9) return 1'b0;
    if (dec(set_sec) > 59 || dec(set_min) > 59 || dec(set_hour) > 23) return 1'b0;
    if (dec(set_mon) < 1 || dec(set_mon) > 12) return 1'b0;
    return dec(set_day) >= 1 &&
           dec(set_day) <= dim(dec(set_mon), dec(set_cent) * 100 + dec(set_year));
  endfunction

  task automatic model_reset();
    m_sec = 0; m_min = 0; m_hour = 0; m_day = 1; m_mon = 1; m_year = 2000; m_pre = 0;
    m_tick = 0; m_ack = 0; m_err = 0;
  endtask

  task automatic advance_second();
    m_sec++;
    if (m_sec == 60) begin
      m_sec = 0; m_min++;
      if (m_min == 60) begin
        m_min = 0; m_hour++;
        if (m_hour == 24) begin
          m_hour = 0; m_day++;
          if (m_day > dim(m_mon, m_year)) begin
            m_day = 1; m_mon++;
            if (m_mon == 13) begin
              m_mon = 1; m_year = (m_year + 1) % 10000;
            end
          end
        end
      end
    end
  endtask

  task automatic model_edge();
    bit ok, wr;
    ok = set_stb && set_valid();
    wr = ce_in && run && (m_pre == TPS - 1);
    m_ack = ok; m_err = set_stb && !ok; m_tick = wr && !ok;
    if (ok) begin
      m_sec = dec(set_sec); m_min = dec(set_min); m_hour = dec(set_hour);
      m_day = dec(set_day); m_mon = dec(set_mon);
      m_year = dec(set_cent) * 100 + dec(set_year); m_pre = 0;
    end else begin
      if (ce_in && run) m_pre = wr ? 0 : m_pre + 1;
      if (wr) advance_second();
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("sec", sec_bcd, bcd(m_sec));
    chk("min", min_bcd, bcd(m_min));
    chk("hour", hour_bcd, bcd(m_hour));
    chk("day", day_bcd, bcd(m_day));
    chk("mon", mon_bcd, bcd(m_mon));
    chk("year", year_bcd, bcd(m_year % 100));
    chk("cent", cent_bcd, bcd(m_year / 100));
    chk("tick_1hz", {7'd0, tick_1hz}, {7'd0, m_tick});
    chk("set_ack", {7'd0, set_ack}, {7'd0, m_ack});
    chk("set_err", {7'd0, set_err}, {7'd0, m_err});
  endtask

  task automatic cyc(input bit ce, input bit rn, input bit st);
    ce_in = ce; run = rn; set_stb = st;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    set_stb = 1'b0;
  endtask

  task automatic load_set(input int y, input int mo, input int d, input int h,
                          input int mi, input int s);
    set_cent = bcd(y / 100); set_year = bcd(y % 100); set_mon = bcd(mo);
    set_day = bcd(d); set_hour = bcd(h); set_min = bcd(mi); set_sec = bcd(s);
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    rst = 1'b0;

    repeat (12) cyc(1, 1, 0);
    chk("sec_after_12_ce", sec_bcd, 8'h03);

    load_set(1999, 12, 31, 23, 59, 59); cyc(0, 1, 1);
    repeat (TPS) cyc(1, 1, 0);
    chk("y2k_cent", cent_bcd, 8'h20);
    chk("y2k_year", year_bcd, 8'h00);
    chk("y2k_day", day_bcd, 8'h01);

    load_set(2024, 2, 28, 23, 59, 59); cyc(0, 1, 1);
    repeat (TPS) cyc(1, 1, 0);
    chk("leap2024_day", day_bcd, 8'h29);
    load_set(2100, 2, 28, 23, 59, 59); cyc(0, 1, 1);
    repeat (TPS) cyc(1, 1, 0);
    chk("noleap2100_mon", mon_bcd, 8'h03);
    load_set(2000, 2, 29, 23, 59, 59); cyc(0, 1, 1);
    repeat (TPS) cyc(1, 1, 0);
    chk("leap2000_day", day_bcd, 8'h01);

    load_set(2023, 2, 29, 10, 10, 10); cyc(0, 1, 1);
    chk("bad_feb29_err", {7'd0, set_err}, 8'h01);
    load_set(2023, 5, 5, 10, 10, 10); set_min = 8'h5A; cyc(1, 1, 1);
    chk("bad_min_err", {7'd0, set_err}, 8'h01);

    for (int i = 0; i < TPS && m_pre != TPS - 1; i++) cyc(1, 1, 0);
    load_set(2050, 6, 15, 12, 30, 45); cyc(1, 1, 1);
    chk("set_beats_adv_tick", {7'd0, tick_1hz}, 8'h00);
    chk("set_beats_adv_sec", sec_bcd, 8'h45);

    cyc(1, 1, 0); cyc(1, 1, 0);
    repeat (10) cyc(1, 0, 0);
    cyc(1, 1, 0); cyc(1, 1, 0);
    chk("resume_tick", {7'd0, tick_1hz}, 8'h01);
    chk("resume_sec", sec_bcd, 8'h46);

    load_set(9999, 12, 31, 23, 59, 59); cyc(0, 0, 1);
    repeat (TPS) cyc(1, 1, 0);
    chk("wrap_cent", cent_bcd, 8'h00);
    chk("wrap_year", year_bcd, 8'h00);

    repeat (400) begin
      bit st;
      st = ($urandom_range(0, 11) == 0);
      if (st) begin
        load_set($urandom_range(0, 9999), $urandom_range(1, 12), $urandom_range(28, 31),
                 ($urandom_range(0, 1) != 0) ? 23 : $urandom_range(0, 23),
                 ($urandom_range(0, 1) != 0) ? 59 : $urandom_range(0, 59),
                 ($urandom_range(0, 3) != 0) ? 59 : $urandom_range(0, 59));
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 3))
            0: set_sec  = 8'($urandom);
            1: set_hour = 8'($urandom);
            2: set_mon  = 8'($urandom);
            default: set_day = 8'($urandom);
          endcase
        end
      end
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, st);
    end

    cyc(1, 1, 0); cyc(1, 1, 0);
    load_set(2031, 7, 7, 7, 7, 7); set_stb = 1'b1;
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    set_stb = 1'b0;
    #3 rst = 1'b0;
    repeat (6) cyc(1, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
